// File: rtl/fcs_pkg.sv
// ============================================================================
// Module      : fcs_pkg
// Description : Shared constants, FSM state type and bit-order helper for the
//               Ethernet FCS appender.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fcs_pkg;

    localparam logic [31:0] CRC_POLY   = 32'h04C11DB7;
    localparam logic [31:0] CRC_INIT   = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_XOROUT = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAD  = 2'd2,
        FCS  = 2'd3
    } state_t;

    // Mirrors bit order inside each byte; byte positions are untouched.
    function automatic logic [31:0] bitrev_bytes(input logic [31:0] x);
        logic [31:0] r;
        r = '0;
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 8; i++) begin
                r[b*8 + i] = x[b*8 + 7 - i];
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/crc32_d32.sv
// ============================================================================
// Module      : crc32_d32
// Description : Combinational CRC-32 update over one 32-bit word, byte [7:0]
//               first, MSB-first register with reflected byte input.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module crc32_d32
    import fcs_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [31:0] data_in,
    output logic [31:0] crc_out
);

    logic [31:0] w_data_rev;
    logic [31:0] w_crc;

    assign w_data_rev = bitrev_bytes(data_in);

    always_comb begin
        w_crc = crc_in;
        for (int b = 0; b < 4; b++) begin
            w_crc = w_crc ^ {w_data_rev[b*8 +: 8], 24'h000000};
            for (int i = 0; i < 8; i++) begin
                w_crc = w_crc[31] ? ((w_crc << 1) ^ CRC_POLY) : (w_crc << 1);
            end
        end
    end

    assign crc_out = w_crc;

endmodule

`default_nettype wire

// File: rtl/fcs_append.sv
// ============================================================================
// Module      : fcs_append
// Description : Streams 32-bit frame words, pads short frames with zero words
//               and appends the CRC-32 FCS word behind a single output stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fcs_append
    import fcs_pkg::*;
#(
    parameter int MIN_WORDS = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_sof,
    input  logic        in_eof,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_sof,
    output logic        out_eof,
    output logic        err
);

    localparam logic [15:0] c_min_words = 16'(MIN_WORDS);

    state_t      r_state;
    state_t      w_state_nxt;
    logic        r_live;
    logic [31:0] r_crc;
    logic [15:0] r_count;
    logic        r_out_valid;
    logic [31:0] r_out_data;
    logic        r_out_sof;
    logic        r_out_eof;
    logic        r_err;

    logic        w_out_free;
    logic        w_in_ready;
    logic        w_accept;
    logic        w_restart;
    logic [31:0] w_crc_seed;
    logic [31:0] w_crc_word;
    logic [31:0] w_crc_next;
    logic [15:0] w_cnt_inc;
    logic        w_short;
    logic [31:0] w_fcs;
    logic        w_emit;
    logic [31:0] w_emit_data;
    logic        w_emit_sof;
    logic        w_emit_eof;
    logic        w_upd;
    logic        w_err;

    crc32_d32 u_crc (
        .crc_in  (w_crc_seed),
        .data_in (w_crc_word),
        .crc_out (w_crc_next)
    );

    assign w_out_free = !r_out_valid || out_ready;
    assign w_in_ready = r_live && (r_state == IDLE || r_state == DATA) && w_out_free;
    assign w_accept   = in_valid && w_in_ready;
    // A sof word always opens a fresh CRC/count, even when it truncates a frame.
    assign w_restart  = (r_state == IDLE) || (r_state == DATA && in_sof);
    assign w_crc_seed = w_restart ? CRC_INIT : r_crc;
    assign w_crc_word = (r_state == PAD) ? 32'h0 : in_data;
    assign w_cnt_inc  = w_restart ? 16'd1 :
                        (r_count == 16'hFFFF) ? r_count : r_count + 16'd1;
    assign w_short    = w_cnt_inc < c_min_words;
    assign w_fcs      = bitrev_bytes({r_crc[7:0], r_crc[15:8], r_crc[23:16], r_crc[31:24]})
                        ^ CRC_XOROUT;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: if (w_accept && in_sof) w_state_nxt = !in_eof ? DATA : (w_short ? PAD : FCS);
            DATA: if (w_accept && in_eof) w_state_nxt = w_short ? PAD : FCS;
            PAD:  if (w_out_free && !w_short) w_state_nxt = FCS;
            FCS:  if (w_out_free) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_emit      = 1'b0;
        w_emit_data = in_data;
        w_emit_sof  = 1'b0;
        w_emit_eof  = 1'b0;
        w_upd       = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (in_sof) begin
                        w_emit     = 1'b1;
                        w_emit_sof = 1'b1;
                        w_upd      = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
                end
            end
            DATA: begin
                if (w_accept) begin
                    w_emit     = 1'b1;
                    w_upd      = 1'b1;
                    w_emit_eof = in_sof;
                    w_err      = in_sof;
                end
            end
            PAD: begin
                if (w_out_free) begin
                    w_emit      = 1'b1;
                    w_emit_data = 32'h0;
                    w_upd       = 1'b1;
                end
            end
            FCS: begin
                if (w_out_free) begin
                    w_emit      = 1'b1;
                    w_emit_data = w_fcs;
                    w_emit_eof  = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live      <= 1'b0;
            r_crc       <= CRC_INIT;
            r_count     <= 16'd0;
            r_out_valid <= 1'b0;
            r_out_data  <= 32'h0;
            r_out_sof   <= 1'b0;
            r_out_eof   <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_live <= 1'b1;
            r_err  <= w_err;
            if (w_upd) begin
                r_crc   <= w_crc_next;
                r_count <= w_cnt_inc;
            end
            if (w_emit) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_emit_data;
                r_out_sof   <= w_emit_sof;
                r_out_eof   <= w_emit_eof;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_sof   = r_out_sof;
    assign out_eof   = r_out_eof;
    assign err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_fcs_append.sv
// ============================================================================
// Module      : tb_fcs_append
// Description : Self-checking bench for fcs_append with MIN_WORDS=0 and 15.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_fcs_append;

    typedef struct packed {
        logic [31:0] data;
        logic        sof;
        logic        eof;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_n     [2];
    logic        in_valid  [2];
    logic        in_ready  [2];
    logic [31:0] in_data   [2];
    logic        in_sof    [2];
    logic        in_eof    [2];
    logic        out_valid [2];
    logic        out_ready [2];
    logic [31:0] out_data  [2];
    logic        out_sof   [2];
    logic        out_eof   [2];
    logic        err       [2];

    int          n_checks = 0;
    int          n_pass   = 0;
    int          err_seen [2];
    int          err_exp  [2];
    bit          bp_en    [2];
    bit          hold_v   [2];
    logic [34:0] hold_b   [2];
    beat_t       exp_q0[$];
    beat_t       exp_q1[$];
    logic [31:0] frm[$];

    always #5 clk = ~clk;

    fcs_append #(.MIN_WORDS(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_data(in_data[0]), .in_sof(in_sof[0]), .in_eof(in_eof[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .out_sof(out_sof[0]), .out_eof(out_eof[0]), .err(err[0])
    );

    fcs_append #(.MIN_WORDS(15)) u_dut15 (
        .clk(clk), .rst_n(rst_n[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_data(in_data[1]), .in_sof(in_sof[1]), .in_eof(in_eof[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .out_sof(out_sof[1]), .out_eof(out_eof[1]), .err(err[1])
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference CRC-32: reflected shift register, bytes taken LSB-first.
    function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [31:0] w);
        logic [31:0] r;
        r = c;
        for (int b = 0; b < 4; b++) begin
            r = r ^ {24'h0, w[b*8 +: 8]};
            for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    function automatic logic [31:0] crc_of_word(input logic [31:0] w);
        return ~crc_upd(32'hFFFFFFFF, w);
    endfunction

    task automatic push_exp(input int d, input logic [31:0] data, input logic sof, input logic eof);
        beat_t b;
        b.data = data; b.sof = sof; b.eof = eof;
        if (d == 0) exp_q0.push_back(b);
        else        exp_q1.push_back(b);
    endtask

    // Expected output of frame frm: words, zero padding to the minimum, FCS.
    task automatic model_frame(input int d, input bit skip_first);
        logic [31:0] c;
        int          n;
        int          minw;
        c    = 32'hFFFFFFFF;
        n    = 0;
        minw = (d == 0) ? 0 : 15;
        for (int k = 0; k < frm.size(); k++) begin
            c = crc_upd(c, frm[k]);
            n++;
            if (!(skip_first && k == 0)) push_exp(d, frm[k], k == 0, 1'b0);
        end
        while (n < minw) begin
            c = crc_upd(c, 32'h0);
            n++;
            push_exp(d, 32'h0, 1'b0, 1'b0);
        end
        push_exp(d, ~c, 1'b0, 1'b1);
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic drive_word(input int d, input logic [31:0] data, input logic sof, input logic eof);
        logic ok;
        in_valid[d] = 1'b1; in_data[d] = data; in_sof[d] = sof; in_eof[d] = eof;
        for (int t = 0; ; t++) begin
            #1;
            ok = in_ready[d];
            @(posedge clk);
            if (ok) break;
            if (t >= 1000) begin
                n_checks++;
                $display("FAIL accept_timeout: dut%0d got in_ready=0 expected 1", d);
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        in_valid[d] = 1'b0; in_sof[d] = 1'b0; in_eof[d] = 1'b0;
    endtask

    task automatic send_frm(input int d, input bit gaps);
        for (int k = 0; k < frm.size(); k++) begin
            if (gaps) repeat ($urandom_range(0, 2)) @(negedge clk);
            drive_word(d, frm[k], k == 0, k == frm.size() - 1);
        end
    endtask

    task automatic drain();
        for (int t = 0; t < 3000 && (exp_q0.size() != 0 || exp_q1.size() != 0); t++)
            @(negedge clk);
        check("drain_dut0", 64'(exp_q0.size()), 64'd0);
        check("drain_dut1", 64'(exp_q1.size()), 64'd0);
    endtask

    // Starting right after an eof acceptance, count cycles with in_ready low.
    task automatic count_ready_low(input int d, output int lowc);
        lowc = 0;
        for (int t = 0; t < 100; t++) begin
            #1;
            if (in_ready[d]) break;
            lowc++;
            @(negedge clk);
        end
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            out_ready[d] = bp_en[d] ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
    end

    always @(negedge clk) begin
        #2;
        for (int d = 0; d < 2; d++) begin
            if (!rst_n[d]) begin
                hold_v[d] = 1'b0;
            end else begin
                if (err[d]) err_seen[d]++;
                if (hold_v[d])
                    check("hold_stable", {29'h0, out_valid[d], out_data[d], out_sof[d], out_eof[d]},
                          {29'h0, hold_b[d]});
                hold_v[d] = out_valid[d] && !out_ready[d];
                hold_b[d] = {out_valid[d], out_data[d], out_sof[d], out_eof[d]};
                if (out_valid[d] && out_ready[d]) begin
                    beat_t e;
                    bit    have;
                    have = (d == 0) ? (exp_q0.size() != 0) : (exp_q1.size() != 0);
                    if (!have) begin
                        n_checks++;
                        $display("FAIL unexpected_out: dut%0d got %h with nothing expected", d, out_data[d]);
                    end else begin
                        e = (d == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                        check(d == 0 ? "out_beat_dut0" : "out_beat_dut1",
                              {30'h0, out_data[d], out_sof[d], out_eof[d]}, {30'h0, e});
                    end
                end
            end
        end
    end

    initial begin
        int lowc;
        for (int d = 0; d < 2; d++) begin
            rst_n[d] = 1'b0; in_valid[d] = 1'b0; in_data[d] = 32'h0;
            in_sof[d] = 1'b0; in_eof[d] = 1'b0; out_ready[d] = 1'b1;
            err_seen[d] = 0; err_exp[d] = 0; bp_en[d] = 1'b0; hold_v[d] = 1'b0;
        end
        repeat (3) @(negedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            check("reset_state", {58'h0, out_valid[d], in_ready[d], out_sof[d], out_eof[d], err[d], 1'b0},
                  64'h0);
            check("reset_data", {32'h0, out_data[d]}, 64'h0);
        end
        @(negedge clk);
        rst_n[0] = 1'b1; rst_n[1] = 1'b1;
        repeat (2) @(negedge clk);

        // Model pins against known CRC-32 values.
        check("model_1234", {32'h0, crc_of_word(32'h34333231)}, {32'h0, 32'h9BE3E0A3});
        check("model_zero", {32'h0, crc_of_word(32'h00000000)}, {32'h0, 32'h2144DF1C});

        // Single-word frames, no padding, literal expectations.
        push_exp(0, 32'h34333231, 1'b1, 1'b0);
        push_exp(0, 32'h9BE3E0A3, 1'b0, 1'b1);
        drive_word(0, 32'h34333231, 1'b1, 1'b1);
        push_exp(0, 32'h00000000, 1'b1, 1'b0);
        push_exp(0, 32'h2144DF1C, 1'b0, 1'b1);
        drive_word(0, 32'h00000000, 1'b1, 1'b1);
        drain();

        // Full throughput: 4-word frame, in_ready drops only for the FCS cycle.
        frm = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00};
        model_frame(0, 1'b0);
        send_frm(0, 1'b0);
        count_ready_low(0, lowc);
        check("ready_low_fcs_only", 64'(lowc), 64'd1);
        drain();

        // Short frame on MIN_WORDS=15: 12 pad words plus FCS.
        frm = '{32'hDEADBEEF, 32'h01020304, 32'hCAFEF00D};
        model_frame(1, 1'b0);
        send_frm(1, 1'b0);
        count_ready_low(1, lowc);
        check("ready_low_pad", 64'(lowc), 64'd13);
        drain();

        // Truncated frame: sof arrives as the 6th word without a prior eof.
        for (int k = 0; k < 5; k++) push_exp(1, 32'hA0000000 + k, k == 0, 1'b0);
        push_exp(1, 32'hB0000000, 1'b0, 1'b1);
        err_exp[1]++;
        frm = '{32'hB0000000, 32'hB0000001, 32'hB0000002};
        model_frame(1, 1'b1);
        for (int k = 0; k < 5; k++) drive_word(1, 32'hA0000000 + k, k == 0, 1'b0);
        drive_word(1, 32'hB0000000, 1'b1, 1'b0);
        drive_word(1, 32'hB0000001, 1'b0, 1'b0);
        drive_word(1, 32'hB0000002, 1'b0, 1'b1);
        drain();
        // A non-sof word while idle is swallowed.
        err_exp[1]++;
        drive_word(1, 32'h12345678, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        check("err_count_dut1", 64'(err_seen[1]), 64'(err_exp[1]));
        check("drop_no_output", 64'(exp_q1.size()), 64'd0);

        // Reset while padding; frame discarded, next frame clean.
        frm = '{32'h0BADF00D, 32'h00C0FFEE};
        model_frame(1, 1'b0);
        send_frm(1, 1'b0);
        repeat (3) @(negedge clk);
        #3;
        rst_n[1] = 1'b0;
        exp_q1.delete();
        #1;
        check("reset_mid_pad", {62'h0, out_valid[1], in_ready[1]}, 64'h0);
        repeat (2) @(negedge clk);
        rst_n[1] = 1'b1;
        frm = '{32'h76543210, 32'hFEDCBA98, 32'h13579BDF, 32'h2468ACE0};
        model_frame(1, 1'b0);
        send_frm(1, 1'b0);
        drain();

        // Random frames under random backpressure.
        bp_en[0] = 1'b1; bp_en[1] = 1'b1;
        for (int f = 0; f < 50; f++) begin
            int len;
            len = $urandom_range(1, 20);
            frm.delete();
            for (int k = 0; k < len; k++) frm.push_back($urandom);
            model_frame(1, 1'b0);
            send_frm(1, 1'b1);
        end
        for (int f = 0; f < 15; f++) begin
            int len;
            len = $urandom_range(1, 8);
            frm.delete();
            for (int k = 0; k < len; k++) frm.push_back($urandom);
            model_frame(0, 1'b0);
            send_frm(0, 1'b1);
        end
        drain();
        repeat (3) @(negedge clk);
        check("err_total_dut0", 64'(err_seen[0]), 64'(err_exp[0]));
        check("err_total_dut1", 64'(err_seen[1]), 64'(err_exp[1]));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/fcs_append.md
FCS_APPEND -- requirements
Module: fcs_append

Interface
REQ-001 SHALL have parameter MIN_WORDS, default 15, minimum frame length in 32-bit words before FCS; 0 disables padding.
REQ-002 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port in_valid  input  1  upstream word valid.
REQ-005 SHALL have port in_ready  output  1  word accepted when in_valid & in_ready.
REQ-006 SHALL have port in_data  input  32  payload word; bits [7:0] = first byte on wire.
REQ-007 SHALL have port in_sof  input  1  first word of frame, qualified by in_valid.
REQ-008 SHALL have port in_eof  input  1  last word of frame, qualified by in_valid; sof&eof = one-word frame.
REQ-009 SHALL have port out_valid / out_ready / out_data[31:0] / out_sof / out_eof with the same meanings downstream.
REQ-010 SHALL have port err  output  1  one-cycle pulse on protocol error.

Function
REQ-011 SHALL compute CRC-32 IEEE 802.3: poly 0x04C11DB7, init 0xFFFFFFFF, per-byte reflected input, reflected output, final XOR 0xFFFFFFFF, over 4 bytes per accepted word.
REQ-012 SHALL use FSM states IDLE, DATA, PAD, FCS.
REQ-013 IDLE: accept only words with in_sof; non-sof words are dropped, err pulses; sof loads CRC with init then updates with the word -> DATA (or PAD/FCS if in_eof).
REQ-014 DATA: each accepted word updates CRC, increments 16-bit word counter (saturating at 0xFFFF); on in_eof -> PAD if count < MIN_WORDS, else FCS.
REQ-015 DATA: in_sof without prior eof SHALL pulse err, output current word with out_eof=1 and no FCS (truncated frame), and restart a new frame with this word.
REQ-016 PAD: in_ready=0; emits 0x00000000 words, each updating CRC and counter, until count == MIN_WORDS -> FCS.
REQ-017 FCS: in_ready=0; emits one word = final CRC, byte0 in [7:0], out_eof=1 -> IDLE.
REQ-018 out_eof SHALL be 1 only on the FCS word (or truncated-frame word per REQ-015); the input eof word is forwarded with out_eof=0.
REQ-019 Output SHALL be one register stage: out_* register loads when empty or out_ready; latency accept-to-out_valid = 1 cycle.
REQ-020 in_ready SHALL equal (state is IDLE or DATA) & (!out_valid | out_ready); no combinational path from in_valid to in_ready.
REQ-021 out_data/out_sof/out_eof SHALL hold stable while out_valid & !out_ready.
REQ-022 Full throughput: with out_ready=1, N-word frame (N >= MIN_WORDS) occupies N+1 output cycles; next sof accepted the cycle after the FCS word is loaded.

Reset
REQ-023 rst_n low SHALL asynchronously force state IDLE, CRC 0xFFFFFFFF, counter 0, out_valid 0, out_sof 0, out_eof 0, out_data 0, err 0, in_ready 0.
REQ-024 Reset mid-frame SHALL discard the frame silently; after release the first accepted word must carry in_sof.

Structure
REQ-025 Package fcs_pkg SHALL hold CRC_POLY, CRC_INIT, CRC_XOROUT, the state enum type, and a function reversing bits within each byte.
REQ-026 Sub-module crc32_d32 (combinational: 32-bit CRC in + 32-bit data in -> 32-bit CRC out, 4 chained byte steps) SHALL be instantiated once.

Verification
REQ-027 MIN_WORDS=0, single word 0x34333231 ("1234") sof&eof -> outputs 0x34333231 (sof, eof=0) then 0x9BE3E0A3 (eof).
REQ-028 MIN_WORDS=0, single word 0x00000000 sof&eof -> FCS word 0x2144DF1C.
REQ-029 MIN_WORDS=15, 3-word frame -> 3 data words, 12 zero pad words, FCS = software CRC of 60 bytes, total 16 output words, in_ready low for 13 cycles.
REQ-030 Random out_ready backpressure over 50 random frames -> output stream matches reference model word-for-word, no drops, no duplicates.
REQ-031 sof mid-frame after 5 words -> err pulse, 6th word out with eof, no FCS; new frame FCS correct; non-sof word in IDLE -> dropped, err pulse.
REQ-032 rst_n low mid-frame during PAD -> out_valid 0 immediately; next full frame yields correct FCS.
